// File: rtl/apb_rr_master.sv
// apb_rr_master
//   Round-robin APB master. It shares one APB slave port among NUM_REQ local
//   requesters. Each requester issues one read or write at a time. The block
//   arbitrates, runs the APB SETUP/ACCESS sequence, absorbs slave wait states,
//   and returns read data and error status to the requester that won.
//
// Ports
//   PCLK, PRESETn             clock, async active-low reset
//   req_valid/write/addr/     per-requester request, packed with requester i
//   wdata/strb                at [i*W +: W]; held stable until req_ready
//   req_ready                 one-hot accept pulse (combinational)
//   rsp_valid                 one-hot 1-cycle completion pulse
//   rsp_rdata, rsp_err        result of the last completed transfer (held)
//   wait_cycles               ACCESS cycles of the last transfer, saturating at 255
//   busy                      transfer in progress (state != IDLE)
//   PSEL..PSTRB, PRDATA,      APB master interface
//   PREADY, PSLVERR
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus idle; every cycle is an arbitration slot
// SETUP  | APB setup phase (PSEL=1, PENABLE=0), always one cycle
// ACCESS | APB access phase; waits for PREADY; the PREADY cycle is a slot

module apb_rr_master #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [7:0]                    wait_cycles,
  output logic                          busy,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [STRB_WIDTH-1:0]         PSTRB,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         owner_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [7:0]            wait_cycles_q;
  logic [7:0]            wait_total;

  // Unpacked views of the packed request buses
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [STRB_WIDTH-1:0] strb_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[g]  = req_strb[g*STRB_WIDTH +: STRB_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester starting one past the pointer.
  // cand is one bit wider than the index so ptr+i never wraps before the
  // explicit modulo-NUM_REQ correction.
  // ---------------------------------------------------------------------------
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  logic done;
  logic slot;
  logic grant;

  assign done  = (state_q == ACCESS) && PREADY;
  assign slot  = (state_q == IDLE) || done;
  assign grant = slot && win_found;

  // Gated with PRESETn so no requester sees an accept while the block is held
  // in reset.
  always_comb begin
    req_ready = '0;
    if (PRESETn && grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY) state_d = win_found ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait counter and completion pulse
  // ---------------------------------------------------------------------------
  assign wait_total = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if (state_q == ACCESS) begin
      wait_cnt_d = wait_total;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (done) begin
      rsp_valid_d[owner_q] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(NUM_REQ - 1);
      owner_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      wait_cnt_q    <= '0;
      wait_cycles_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= rsp_valid_d;
      wait_cnt_q  <= wait_cnt_d;

      // Address/data change only on a grant, so they hold through SETUP and
      // every ACCESS cycle, and keep their last values in IDLE.
      if (grant) begin
        ptr_q    <= win_idx;
        owner_q  <= win_idx;
        pwrite_q <= req_write[win_idx];
        paddr_q  <= addr_arr[win_idx];
        pwdata_q <= req_write[win_idx] ? wdata_arr[win_idx] : '0;
        pstrb_q  <= req_write[win_idx] ? strb_arr[win_idx]  : '0;
      end

      if (done) begin
        rdata_q       <= pwrite_q ? '0 : PRDATA;
        err_q         <= PSLVERR;
        wait_cycles_q <= wait_total;
      end
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign wait_cycles = wait_cycles_q;
  assign busy        = (state_q != IDLE);

endmodule
